oven_panel_encoder: RTL and testbench

Front-panel command encoder for the microwave oven controller. Takes the raw, bouncy panel buttons and debounces each one. It detects press edges, auto-repeats the add-minute key, and encodes presses into 3-bit command codes by fixed priority. Commands are queued in a small FIFO and delivered to the oven controller over a valid/ready handshake, so the controller sees one clean command per transfer.

---
 rtl/oven_cmd_pkg.sv | 41 ++++
 rtl/key_debounce.sv | 48 ++++
 rtl/oven_panel_encoder.sv | 136 +++++++++++++
 tb/tb_oven_panel_encoder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/oven_cmd_pkg.sv
// Shared command codes, key indices and priority encoding for the oven panel and controller.
package oven_cmd_pkg;

  localparam int unsigned NUM_KEYS = 7;

  localparam int unsigned KEY_START = 0;
  localparam int unsigned KEY_ADD   = 1;
  localparam int unsigned KEY_UP    = 2;
  localparam int unsigned KEY_MH    = 3;
  localparam int unsigned KEY_ML    = 4;
  localparam int unsigned KEY_DOWN  = 5;
  localparam int unsigned KEY_STOP  = 6;

  localparam logic [2:0] CMD_NONE     = 3'd0;
  localparam logic [2:0] CMD_START    = 3'd1;
  localparam logic [2:0] CMD_ADD      = 3'd2;
  localparam logic [2:0] CMD_PWR_HIGH = 3'd3;
  localparam logic [2:0] CMD_PWR_MH   = 3'd4;
  localparam logic [2:0] CMD_PWR_ML   = 3'd5;
  localparam logic [2:0] CMD_PWR_LOW  = 3'd6;
  localparam logic [2:0] CMD_STOP     = 3'd7;

  // Highest-priority request wins: STOP > START > ADD > HIGH > MH > ML > LOW.
  function automatic logic [2:0] encode_cmd(input logic [NUM_KEYS-1:0] req);
    logic [2:0] code;
    code = CMD_NONE;
    if (req[KEY_STOP])       code = CMD_STOP;
    else if (req[KEY_START]) code = CMD_START;
    else if (req[KEY_ADD])   code = CMD_ADD;
    else if (req[KEY_UP])    code = CMD_PWR_HIGH;
    else if (req[KEY_MH])    code = CMD_PWR_MH;
    else if (req[KEY_ML])    code = CMD_PWR_ML;
    else if (req[KEY_DOWN])  code = CMD_PWR_LOW;
    return code;
  endfunction

  function automatic logic multi_req(input logic [NUM_KEYS-1:0] req);
    return $countones(req) > 1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One panel key: 2-flop synchronizer, stability counter and rising-edge press pulse.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic stable_o,
  output logic press_o
);

  localparam logic [7:0] CntLast = 8'(DEBOUNCE_CYCLES - 1);

  logic       sync1_q, sync2_q;
  logic       stable_q, stable_d;
  logic       prev_q;
  logic [7:0] cnt_q, cnt_d;

  // The cycle the counter would reach DEBOUNCE_CYCLES is the cycle the level flips.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = 8'd0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CntLast) stable_d = ~stable_q;
      else                  cnt_d    = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign press_o  = stable_q & ~prev_q;

endmodule

// File: rtl/oven_panel_encoder.sv
// Panel command encoder: per-key debounce, ADD auto-repeat, priority encode, command FIFO.
module oven_panel_encoder
  import oven_cmd_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_CYCLES   = 16,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          btn_start,
  input  logic                          btn_add,
  input  logic                          btn_up,
  input  logic [1:0]                    btn_mid,
  input  logic                          btn_down,
  input  logic                          btn_stop,
  output logic                          cmd_valid,
  output logic [2:0]                    cmd_code,
  input  logic                          cmd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clr_overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]  LvlFull = FIFO_DEPTH[AW:0];
  localparam logic [15:0]  RptLast = 16'(REPEAT_CYCLES - 1);

  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] key_press;
  logic                key_stable [NUM_KEYS];

  always_comb begin
    key_raw            = '0;
    key_raw[KEY_START] = btn_start;
    key_raw[KEY_ADD]   = btn_add;
    key_raw[KEY_UP]    = btn_up;
    key_raw[KEY_MH]    = btn_mid[1];
    key_raw[KEY_ML]    = btn_mid[0];
    key_raw[KEY_DOWN]  = btn_down;
    key_raw[KEY_STOP]  = btn_stop;
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .reset   (reset),
      .raw_i   (key_raw[k]),
      .stable_o(key_stable[k]),
      .press_o (key_press[k])
    );
  end

  // Repeat counter starts the cycle after the press so the first repeat lands
  // exactly REPEAT_CYCLES after the press push.
  logic [15:0] rpt_q, rpt_d;
  logic        rpt_fire;

  always_comb begin
    rpt_d    = 16'd0;
    rpt_fire = 1'b0;
    if (key_stable[KEY_ADD] && !key_press[KEY_ADD]) begin
      if (rpt_q == RptLast) rpt_fire = 1'b1;
      else                  rpt_d    = rpt_q + 16'd1;
    end
  end

  logic [NUM_KEYS-1:0] req;
  logic [2:0]          push_code;
  logic                push_req, drop_lower;

  always_comb begin
    req          = key_press;
    req[KEY_ADD] = key_press[KEY_ADD] | rpt_fire;
    push_code    = encode_cmd(req);
    push_req     = |req;
    drop_lower   = multi_req(req);
  end

  logic [2:0]    mem_q [FIFO_DEPTH];
  logic [2:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          full, pop, push_ok;

  always_comb begin
    full       = (level_q == LvlFull);
    pop        = (level_q != '0) && cmd_ready;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    push_ok    = push_req && (!full || pop);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_code;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_ok, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    if (clr_overflow) overflow_d = 1'b0;
    if (drop_lower || (push_req && !push_ok)) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= CMD_NONE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      rpt_q      <= 16'd0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      rpt_q      <= rpt_d;
    end
  end

  assign cmd_valid  = (level_q != '0);
  assign cmd_code   = cmd_valid ? mem_q[rd_ptr_q] : CMD_NONE;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_oven_panel_encoder.sv
// Scoreboard bench for oven_panel_encoder: stimulus queues expected codes, a monitor checks pops.
module tb_oven_panel_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_start, btn_add, btn_up, btn_down, btn_stop;
  logic [1:0] btn_mid;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic       cmd_ready;
  logic [2:0] fifo_level;
  logic       overflow;
  logic       clr_overflow;

  int n_checks = 0;
  int n_pass   = 0;
  int sb [$];

  oven_panel_encoder #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES  (16),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_start   (btn_start),
    .btn_add     (btn_add),
    .btn_up      (btn_up),
    .btn_mid     (btn_mid),
    .btn_down    (btn_down),
    .btn_stop    (btn_stop),
    .cmd_valid   (cmd_valid),
    .cmd_code    (cmd_code),
    .cmd_ready   (cmd_ready),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, got, exp);
  endfunction

  // Inputs change 1 time unit after a rising edge, so the falling edge sees what the
  // next rising edge will accept.
  always @(negedge clk) begin
    if (!reset && cmd_valid && cmd_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL sb_unexpected: got code %0d, required no command", cmd_code);
      end else begin
        check("sb_code", int'(cmd_code), sb.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int mism;
    int nvalid;
    logic exp_v;
    logic [4:0] bounce;

    reset = 1'b1; btn_start = 0; btn_add = 0; btn_up = 0; btn_mid = 2'b00;
    btn_down = 0; btn_stop = 0; cmd_ready = 0; clr_overflow = 0;
    tick(2);
    check("rst_valid", int'(cmd_valid), 0);
    check("rst_code", int'(cmd_code), 0);
    check("rst_level", int'(fifo_level), 0);
    check("rst_overflow", int'(overflow), 0);
    reset = 1'b0;

    // Clean press: valid appears after edge 6, exactly one command.
    cmd_ready = 1'b1;
    btn_start = 1'b1;
    sb.push_back(1);
    tick(6);
    check("press_early_valid", int'(cmd_valid), 0);
    tick(1);
    check("press_valid", int'(cmd_valid), 1);
    check("press_code", int'(cmd_code), 1);
    tick(1);
    check("press_popped", int'(cmd_valid), 0);
    btn_start = 1'b0;
    tick(12);
    check("press_single", int'(fifo_level), 0);

    // Bounce: only the final, held rise counts.
    bounce = 5'b01101;
    for (int i = 0; i < 5; i++) begin
      btn_up = bounce[i];
      tick(1);
    end
    btn_up = 1'b1;
    sb.push_back(3);
    tick(6);
    check("bounce_early_valid", int'(cmd_valid), 0);
    tick(1);
    check("bounce_valid", int'(cmd_valid), 1);
    check("bounce_code", int'(cmd_code), 3);
    btn_up = 1'b0;
    tick(12);

    // Simultaneous STOP and DOWN: STOP queued, DOWN dropped.
    btn_stop = 1'b1;
    btn_down = 1'b1;
    sb.push_back(7);
    tick(7);
    check("simul_code", int'(cmd_code), 7);
    check("simul_overflow", int'(overflow), 1);
    tick(1);
    check("simul_single", int'(cmd_valid), 0);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    check("clr_overflow", int'(overflow), 0);
    btn_stop = 1'b0;
    btn_down = 1'b0;
    tick(12);

    // Auto-repeat: ADD at edges 6, 22, 38, 54 while held for 60 samples.
    repeat (4) sb.push_back(2);
    btn_add = 1'b1;
    mism = 0;
    nvalid = 0;
    for (int e = 0; e < 80; e++) begin
      tick(1);
      exp_v = (e == 6) || (e == 22) || (e == 38) || (e == 54);
      if (cmd_valid !== exp_v) mism++;
      if (cmd_valid) nvalid++;
      if (e == 59) btn_add = 1'b0;
    end
    check("repeat_timing_mism", mism, 0);
    check("repeat_count", nvalid, 4);

    // Full FIFO: five staggered presses with no consumer.
    cmd_ready = 1'b0;
    btn_start = 1'b1; tick(2);
    btn_up = 1'b1; tick(2);
    btn_mid[1] = 1'b1; tick(2);
    btn_mid[0] = 1'b1; tick(2);
    btn_down = 1'b1; tick(10);
    sb.push_back(1); sb.push_back(3); sb.push_back(4); sb.push_back(5);
    check("full_level", int'(fifo_level), 4);
    check("full_overflow", int'(overflow), 1);
    check("full_head", int'(cmd_code), 1);
    btn_start = 0; btn_up = 0; btn_mid = 2'b00; btn_down = 0;
    tick(10);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;

    // Push and pop at full in the same cycle (STOP push lands at edge 6).
    btn_stop = 1'b1;
    sb.push_back(7);
    tick(6);
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    check("fullpp_level", int'(fifo_level), 4);
    check("fullpp_head", int'(cmd_code), 3);
    check("fullpp_overflow", int'(overflow), 0);
    btn_stop = 1'b0;
    cmd_ready = 1'b1;
    tick(6);
    check("drain_level", int'(fifo_level), 0);
    cmd_ready = 1'b0;
    tick(8);

    // Reset mid-queue with START still held.
    btn_up = 1'b1; tick(2);
    btn_start = 1'b1; tick(8);
    check("preq_level", int'(fifo_level), 2);
    reset = 1'b1;
    #1;
    check("midrst_valid", int'(cmd_valid), 0);
    check("midrst_code", int'(cmd_code), 0);
    check("midrst_level", int'(fifo_level), 0);
    check("midrst_overflow", int'(overflow), 0);
    btn_up = 1'b0;
    tick(2);
    reset = 1'b0;
    sb.push_back(1);
    tick(6);
    check("postrst_early_valid", int'(cmd_valid), 0);
    tick(1);
    check("postrst_valid", int'(cmd_valid), 1);
    check("postrst_code", int'(cmd_code), 1);
    check("postrst_level", int'(fifo_level), 1);
    cmd_ready = 1'b1;
    tick(2);
    btn_start = 1'b0;
    tick(10);
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
